// File: rtl/dm_arbiter.sv
// dm_arbiter: single-port data-memory arbiter/sequencer between the pipeline
// M stage and a secondary word-wide bus master (DMA/debug).
//
// One access is issued at a time to a fixed-latency DM. Writes complete in the
// issue cycle. Reads hold the arbiter busy until the data returns MEM_LAT
// cycles later. The pipeline normally wins arbitration, but after STARVE_MAX
// consecutive pipeline issues with a DMA request pending, the DMA is forced
// through.
//
// Ports:
//   i_clk, i_rst_n         clock, synchronous active-low reset
//   i_m*                   M-stage request (req, write, addr, wd, op width, load signed)
//   o_mstall/o_mdone/o_mrd M-stage stall, completion strobe, load data
//   i_d*                   DMA request (req, write, word addr, wd)
//   o_dgnt/o_dvalid/o_drd  DMA issue pulse, read-data pulse, read data
//   o_mem_*                DM issue strobe and access fields
//   i_mem_rd               DM read data, valid MEM_LAT cycles after read issue
module dm_arbiter #(
  parameter int unsigned MEM_LAT    = 2,  // 1..7
  parameter int unsigned STARVE_MAX = 4   // 1..7
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  // M stage
  input  logic        i_mreq,
  input  logic        i_mwrite,
  input  logic [31:0] i_maddr,
  input  logic [31:0] i_mwd,
  input  logic [1:0]  i_mop_width,
  input  logic        i_mload_signed,
  output logic        o_mstall,
  output logic        o_mdone,
  output logic [31:0] o_mrd,
  // DMA / debug master
  input  logic        i_dreq,
  input  logic        i_dwrite,
  input  logic [31:0] i_daddr,
  input  logic [31:0] i_dwd,
  output logic        o_dgnt,
  output logic        o_dvalid,
  output logic [31:0] o_drd,
  // Data memory
  output logic        o_mem_en,
  output logic        o_mem_write,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wd,
  output logic [1:0]  o_mem_op_width,
  output logic        o_mem_load_signed,
  input  logic [31:0] i_mem_rd
);

  typedef enum logic [0:0] {StIdle, StRdBusy} state_e;
  typedef enum logic [0:0] {OwnPipe, OwnDma} owner_e;

  localparam logic [2:0] LatCnt    = 3'(MEM_LAT);
  localparam logic [2:0] StarveCnt = 3'(STARVE_MAX);

  state_e     r_state;
  owner_e     r_owner;
  logic [2:0] r_cnt;
  logic [2:0] r_scnt;

  logic w_idle;
  logic w_dma_win;
  logic w_issue_pipe;
  logic w_issue_dma;
  logic w_complete;
  logic w_pipe_done;
  logic w_unused_daddr;

  // DMA accesses are word-wide; the low address bits carry no information.
  assign w_unused_daddr = ^i_daddr[1:0];

  assign w_idle       = (r_state == StIdle);
  assign w_dma_win    = i_dreq & (~i_mreq | (r_scnt == StarveCnt));
  assign w_issue_dma  = w_idle & w_dma_win;
  assign w_issue_pipe = w_idle & i_mreq & ~w_dma_win;
  assign w_complete   = (r_state == StRdBusy) && (r_cnt == LatCnt);
  // Pipeline finishes either on a store issue or on its own read completion.
  assign w_pipe_done  = (w_issue_pipe & i_mwrite) | (w_complete & (r_owner == OwnPipe));

  // Outputs are forced low while reset is asserted.
  always_comb begin
    o_mstall          = 1'b0;
    o_mdone           = 1'b0;
    o_mrd             = '0;
    o_dgnt            = 1'b0;
    o_dvalid          = 1'b0;
    o_drd             = '0;
    o_mem_en          = 1'b0;
    o_mem_write       = 1'b0;
    o_mem_addr        = '0;
    o_mem_wd          = '0;
    o_mem_op_width    = '0;
    o_mem_load_signed = 1'b0;
    if (i_rst_n) begin
      o_mdone  = w_pipe_done;
      o_mstall = i_mreq & ~w_pipe_done;
      o_dgnt   = w_issue_dma;
      o_dvalid = w_complete & (r_owner == OwnDma);
      if (w_complete && (r_owner == OwnPipe)) begin
        o_mrd = i_mem_rd;
      end
      if (w_complete && (r_owner == OwnDma)) begin
        o_drd = i_mem_rd;
      end
      if (w_issue_pipe) begin
        o_mem_en          = 1'b1;
        o_mem_write       = i_mwrite;
        o_mem_addr        = i_maddr;
        o_mem_wd          = i_mwd;
        o_mem_op_width    = i_mop_width;
        o_mem_load_signed = i_mload_signed;
      end else if (w_issue_dma) begin
        o_mem_en    = 1'b1;
        o_mem_write = i_dwrite;
        o_mem_addr  = {i_daddr[31:2], 2'b00};
        o_mem_wd    = i_dwd;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_owner <= OwnPipe;
      r_cnt   <= '0;
      r_scnt  <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_issue_pipe && !i_mwrite) begin
            r_state <= StRdBusy;
            r_owner <= OwnPipe;
            r_cnt   <= 3'd1;
          end else if (w_issue_dma && !i_dwrite) begin
            r_state <= StRdBusy;
            r_owner <= OwnDma;
            r_cnt   <= 3'd1;
          end
        end
        StRdBusy: begin
          if (w_complete) begin
            r_state <= StIdle;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        default: r_state <= StIdle;
      endcase

      // Count pipeline wins while the DMA waits; saturate at the forcing point.
      if (!i_dreq || w_issue_dma) begin
        r_scnt <= '0;
      end else if (w_issue_pipe && (r_scnt != StarveCnt)) begin
        r_scnt <= r_scnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
module tb_dm_arbiter;
  localparam int unsigned Lat  = 2;
  localparam int unsigned SMax = 4;
  localparam logic O = 1'b0;
  localparam logic I = 1'b1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        mreq, mwrite, mls;
  logic [31:0] maddr, mwd;
  logic [1:0]  mopw;
  logic        mstall, mdone;
  logic [31:0] mrd;
  logic        dreq, dwrite;
  logic [31:0] daddr, dwd;
  logic        dgnt, dvalid;
  logic [31:0] drd;
  logic        mem_en, mem_write, mem_ls;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic [1:0]  mem_opw;

  dm_arbiter #(.MEM_LAT(Lat), .STARVE_MAX(SMax)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_mreq(mreq), .i_mwrite(mwrite), .i_maddr(maddr), .i_mwd(mwd),
    .i_mop_width(mopw), .i_mload_signed(mls),
    .o_mstall(mstall), .o_mdone(mdone), .o_mrd(mrd),
    .i_dreq(dreq), .i_dwrite(dwrite), .i_daddr(daddr), .i_dwd(dwd),
    .o_dgnt(dgnt), .o_dvalid(dvalid), .o_drd(drd),
    .o_mem_en(mem_en), .o_mem_write(mem_write), .o_mem_addr(mem_addr),
    .o_mem_wd(mem_wd), .o_mem_op_width(mem_opw), .o_mem_load_signed(mem_ls),
    .i_mem_rd(mem_rd)
  );

  // DM model: read-only word contents derived from the address, fixed latency.
  // Cycles without a read issue push a filler so wrong-cycle sampling shows.
  function automatic logic [31:0] dm_word(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {16'hC0DE, a[15:0]};
  endfunction

  logic [31:0] rd_pipe [Lat];
  assign mem_rd = rd_pipe[Lat-1];
  always @(posedge clk) begin
    rd_pipe[0] <= (mem_en && !mem_write) ? dm_word(mem_addr) : 32'hA5A5A5A5;
    for (int i = 1; i < Lat; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    mreq = 0; mwrite = 0; maddr = '0; mwd = '0; mopw = '0; mls = 0;
    dreq = 0; dwrite = 0; daddr = '0; dwd = '0;
  endtask

  typedef struct {
    logic        mreq, mwrite;
    logic [31:0] maddr, mwd;
    logic [1:0]  mopw;
    logic        mls;
    logic        dreq, dwrite;
    logic [31:0] daddr, dwd;
    logic        e_mstall, e_mdone, e_dgnt;
    logic        e_en, e_we;
    logic [31:0] e_addr, e_wd;
    logic [1:0]  e_opw;
    logic        e_ls;
  } vec_t;

  vec_t vecs [14];

  initial begin
    // Single-cycle issue vectors; all writes, so the arbiter stays idle.
    vecs[0]  = '{O,O,32'h0,32'h0,2'd0,O, O,O,32'h0,32'h0, O,O,O, O,O,32'h0,32'h0,2'd0,O};
    vecs[1]  = '{I,I,32'h200,32'h12345678,2'd0,O, O,O,32'h0,32'h0,
                 O,I,O, I,I,32'h200,32'h12345678,2'd0,O};
    vecs[2]  = '{I,I,32'h204,32'hAABBCCDD,2'd1,O, O,O,32'h0,32'h0,
                 O,I,O, I,I,32'h204,32'hAABBCCDD,2'd1,O};
    vecs[3]  = '{O,O,32'h0,32'h0,2'd0,O, I,I,32'h303,32'h55,
                 O,O,I, I,I,32'h300,32'h55,2'd0,O};
    vecs[4]  = '{I,I,32'h207,32'h11,2'd2,I, O,O,32'h0,32'h0,
                 O,I,O, I,I,32'h207,32'h11,2'd2,I};
    // DMA write held; four pipeline stores win, the fifth arbitration goes to DMA.
    for (int k = 0; k < 4; k++) begin
      vecs[5+k] = '{I,I,32'h210+32'(4*k),32'hF0+32'(k),2'd0,O, I,I,32'h40E,32'hCAFE,
                    O,I,O, I,I,32'h210+32'(4*k),32'hF0+32'(k),2'd0,O};
    end
    vecs[9]  = '{I,I,32'h220,32'hF4,2'd0,O, I,I,32'h40E,32'hCAFE,
                 I,O,I, I,I,32'h40C,32'hCAFE,2'd0,O};
    // New DMA request right after the grant: counter restarted, pipeline wins.
    vecs[10] = '{I,I,32'h220,32'hF4,2'd0,O, I,I,32'h600,32'h66,
                 O,I,O, I,I,32'h220,32'hF4,2'd0,O};
    vecs[11] = '{I,I,32'h224,32'hF5,2'd0,O, I,I,32'h600,32'h66,
                 O,I,O, I,I,32'h224,32'hF5,2'd0,O};
    vecs[12] = '{O,O,32'h0,32'h0,2'd0,O, I,I,32'h600,32'h66,
                 O,O,I, I,I,32'h600,32'h66,2'd0,O};
    vecs[13] = '{O,O,32'h0,32'h0,2'd0,O, O,O,32'h0,32'h0, O,O,O, O,O,32'h0,32'h0,2'd0,O};

    // Reset with both requesters active: every output held low.
    idle_in();
    rst_n = 0; mreq = 1; dreq = 1;
    next(); next();
    #4;
    chk("rst_mstall", 32'(mstall), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_dgnt", 32'(dgnt), 32'd0);
    chk("rst_mdone", 32'(mdone), 32'd0);
    next();
    rst_n = 1; idle_in();
    #4;
    chk("post_rst_mstall", 32'(mstall), 32'd0);
    chk("post_rst_mem_en", 32'(mem_en), 32'd0);
    next();

    // Pipeline load 0x100.
    mreq = 1; mwrite = 0; maddr = 32'h100;
    #4;
    chk("ld_issue_en", 32'(mem_en), 32'd1);
    chk("ld_issue_we", 32'(mem_write), 32'd0);
    chk("ld_issue_addr", mem_addr, 32'h100);
    chk("ld_t0_stall", 32'(mstall), 32'd1);
    chk("ld_t0_done", 32'(mdone), 32'd0);
    next(); #4;
    chk("ld_t1_en", 32'(mem_en), 32'd0);
    chk("ld_t1_stall", 32'(mstall), 32'd1);
    chk("ld_t1_mrd", mrd, 32'd0);
    next(); #4;
    chk("ld_t2_done", 32'(mdone), 32'd1);
    chk("ld_t2_mrd", mrd, 32'hDEADBEEF);
    chk("ld_t2_stall", 32'(mstall), 32'd0);
    chk("ld_t2_en", 32'(mem_en), 32'd0);
    next();
    idle_in(); #4;
    chk("ld_t3_done", 32'(mdone), 32'd0);
    next();

    // DMA read of unaligned address 0x103.
    dreq = 1; dwrite = 0; daddr = 32'h103; mopw = 2'd2;
    #4;
    chk("dr_gnt", 32'(dgnt), 32'd1);
    chk("dr_addr", mem_addr, 32'h100);
    chk("dr_opw", 32'(mem_opw), 32'd0);
    next();
    dreq = 0; #4;
    chk("dr_t1_valid", 32'(dvalid), 32'd0);
    chk("dr_t1_drd", drd, 32'd0);
    next(); #4;
    chk("dr_t2_valid", 32'(dvalid), 32'd1);
    chk("dr_t2_drd", drd, 32'hDEADBEEF);
    chk("dr_t2_mdone", 32'(mdone), 32'd0);
    next();
    idle_in();

    // DMA request arrives during a pipeline read: grant only after MDone.
    mreq = 1; maddr = 32'h104;
    #4;
    chk("ov_issue_en", 32'(mem_en), 32'd1);
    next();
    dreq = 1; daddr = 32'h108; #4;
    chk("ov_t1_gnt", 32'(dgnt), 32'd0);
    chk("ov_t1_en", 32'(mem_en), 32'd0);
    chk("ov_t1_stall", 32'(mstall), 32'd1);
    next(); #4;
    chk("ov_t2_done", 32'(mdone), 32'd1);
    chk("ov_t2_mrd", mrd, 32'hC0DE0104);
    chk("ov_t2_gnt", 32'(dgnt), 32'd0);
    next();
    mreq = 0; #4;
    chk("ov_t3_gnt", 32'(dgnt), 32'd1);
    chk("ov_t3_addr", mem_addr, 32'h108);
    next();
    dreq = 0; #4;
    chk("ov_t4_valid", 32'(dvalid), 32'd0);
    next(); #4;
    chk("ov_t5_valid", 32'(dvalid), 32'd1);
    chk("ov_t5_drd", drd, 32'hC0DE0108);
    next();
    idle_in();

    // Reset one cycle after a pipeline read issue: read is abandoned.
    mreq = 1; maddr = 32'h10C;
    #4;
    chk("rr_issue_en", 32'(mem_en), 32'd1);
    next();
    rst_n = 0; #4;
    chk("rr_t1_stall", 32'(mstall), 32'd0);
    chk("rr_t1_done", 32'(mdone), 32'd0);
    next();
    rst_n = 1; mreq = 0; #4;
    chk("rr_t2_done", 32'(mdone), 32'd0);
    chk("rr_t2_valid", 32'(dvalid), 32'd0);
    chk("rr_t2_mrd", mrd, 32'd0);
    next(); #4;
    chk("rr_t3_done", 32'(mdone), 32'd0);
    chk("rr_t3_en", 32'(mem_en), 32'd0);
    next();

    // Table-driven single-cycle vectors.
    for (int v = 0; v < 14; v++) begin
      mreq = vecs[v].mreq; mwrite = vecs[v].mwrite; maddr = vecs[v].maddr;
      mwd = vecs[v].mwd; mopw = vecs[v].mopw; mls = vecs[v].mls;
      dreq = vecs[v].dreq; dwrite = vecs[v].dwrite; daddr = vecs[v].daddr; dwd = vecs[v].dwd;
      #4;
      chk($sformatf("v%0d_mstall", v), 32'(mstall), 32'(vecs[v].e_mstall));
      chk($sformatf("v%0d_mdone", v), 32'(mdone), 32'(vecs[v].e_mdone));
      chk($sformatf("v%0d_dgnt", v), 32'(dgnt), 32'(vecs[v].e_dgnt));
      chk($sformatf("v%0d_mem_en", v), 32'(mem_en), 32'(vecs[v].e_en));
      chk($sformatf("v%0d_mem_we", v), 32'(mem_write), 32'(vecs[v].e_we));
      chk($sformatf("v%0d_mem_addr", v), mem_addr, vecs[v].e_addr);
      chk($sformatf("v%0d_mem_wd", v), mem_wd, vecs[v].e_wd);
      chk($sformatf("v%0d_mem_opw", v), 32'(mem_opw), 32'(vecs[v].e_opw));
      chk($sformatf("v%0d_mem_ls", v), 32'(mem_ls), 32'(vecs[v].e_ls));
      chk($sformatf("v%0d_mrd", v), mrd, 32'd0);
      chk($sformatf("v%0d_dvalid", v), 32'(dvalid), 32'd0);
      next();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
